mux_2x1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 2:1 sequential mux (`mux_2x1_seq`). Two upstream requesters share one downstream port. The block decides which branch owns the mux and drives the mux's `i_en`/`i_cmd`. It also returns a one-hot grant/ready to the requesters and honours downstream backpressure. It is instantiated next to each `mux_2x1_seq` in the NoC merge stages.

---
 rtl/mux_2x1_arbiter.sv | 135 +++++++++++++
 tb/tb_mux_2x1_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// rtl/mux_2x1_arbiter.sv - round-robin arbiter/sequencer driving a 2:1 sequential mux
// Optional burst lock enabled by defining ARB_BURST_LOCK_EN.
module mux_2x1_arbiter #(
    parameter int MAX_HOLD  = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_last,
    input  logic       i_out_ready,
    output logic [1:0] o_grant,
    output logic       o_en,
    output logic       o_cmd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_LO = 2'd1,
        GNT_HI = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t rr_nxt;
    logic   last_served;
    logic   cur;
    logic   own_req;
    logic   other_req;
    logic   xfer;

    function automatic state_t gnt_of(input logic branch);
        return branch ? GNT_HI : GNT_LO;
    endfunction

    always_comb begin
        cur       = (state == GNT_HI);
        own_req   = i_req[cur];
        other_req = i_req[!cur];
        xfer      = (state != IDLE) && own_req && i_out_ready;
    end

    // Plain per-transfer round robin; burst lock only overrides it.
    always_comb begin
        rr_nxt = state;
        case (state)
            IDLE: begin
                if (i_req == 2'b11)
                    rr_nxt = gnt_of(!last_served);
                else if (i_req[0])
                    rr_nxt = GNT_LO;
                else if (i_req[1])
                    rr_nxt = GNT_HI;
                else
                    rr_nxt = IDLE;
            end
            GNT_LO, GNT_HI: begin
                if (xfer)
                    rr_nxt = other_req ? gnt_of(!cur) : state;
                else if (!own_req)
                    rr_nxt = other_req ? gnt_of(!cur) : IDLE;
                else
                    rr_nxt = state;
            end
            default: rr_nxt = IDLE;
        endcase
    end

`ifdef ARB_BURST_LOCK_EN
    localparam logic [CNT_WIDTH:0] MAX_HOLD_C = (CNT_WIDTH + 1)'(MAX_HOLD);

    logic [CNT_WIDTH-1:0] hold_cnt;
    logic [CNT_WIDTH-1:0] hold_cnt_nxt;
    logic [CNT_WIDTH:0]   hold_sum;
    logic                 locked;
    logic                 locked_after;
    logic                 locked_nxt;
    logic                 force_switch;

    // A burst is open between its first transfer and the transfer carrying i_last.
    always_comb begin
        hold_sum     = {1'b0, hold_cnt} + {{CNT_WIDTH{1'b0}}, xfer};
        locked_after = xfer ? !i_last[cur] : locked;
        force_switch = (hold_sum >= MAX_HOLD_C) && other_req;
        state_nxt    = rr_nxt;
        if (state != IDLE && locked_after && !force_switch)
            state_nxt = state;
        locked_nxt   = locked_after;
        hold_cnt_nxt = hold_cnt;
        if (state_nxt != state) begin
            locked_nxt   = 1'b0;
            hold_cnt_nxt = '0;
        end else if (hold_sum <= MAX_HOLD_C) begin
            hold_cnt_nxt = hold_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            locked   <= locked_nxt;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^i_last;

    always_comb begin
        state_nxt = rr_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state <= state_nxt;
            if (xfer)
                last_served <= cur;
        end
    end

    always_comb begin
        o_en       = (state != IDLE);
        o_cmd      = (state == GNT_HI);
        o_grant[0] = (state == GNT_LO) && i_out_ready;
        o_grant[1] = (state == GNT_HI) && i_out_ready;
    end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb/tb_mux_2x1_arbiter.sv - self-checking bench for mux_2x1_arbiter
module tb_mux_2x1_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_req;
    logic [1:0] i_last;
    logic       i_out_ready;
    logic [1:0] o_grant;
    logic       o_en;
    logic       o_cmd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: who owns the port (-1 none), who was served last.
    int m_owner;
    int m_last;
    int m_cnt;
    bit m_burst;

    mux_2x1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_last      (i_last),
        .i_out_ready (i_out_ready),
        .o_grant     (o_grant),
        .o_en        (o_en),
        .o_cmd       (o_cmd)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
        m_burst = 0;
    endtask

    task automatic model_step();
        int  nxt;
        int  other;
        bit  xfer;
        bit  burst_after;
        bit  force_sw;
        nxt  = m_owner;
        xfer = 0;
        burst_after = 0;
        if (m_owner < 0) begin
            if (i_req == 2'b11)   nxt = 1 - m_last;
            else if (i_req[0])    nxt = 0;
            else if (i_req[1])    nxt = 1;
            else                  nxt = -1;
        end else begin
            other = 1 - m_owner;
            xfer  = i_req[m_owner] && i_out_ready;
            if (xfer)                nxt = i_req[other] ? other : m_owner;
            else if (!i_req[m_owner]) nxt = i_req[other] ? other : -1;
`ifdef ARB_BURST_LOCK_EN
            burst_after = xfer ? !i_last[m_owner] : m_burst;
            force_sw    = (m_cnt + int'(xfer) >= MAX_HOLD) && i_req[other];
            if (burst_after && !force_sw) nxt = m_owner;
`else
            force_sw = 0;
            if (force_sw) nxt = m_owner;
`endif
            if (xfer) m_last = m_owner;
        end
        if (nxt != m_owner) begin
            m_cnt   = 0;
            m_burst = 0;
        end else begin
            if (m_owner >= 0 && xfer && m_cnt < MAX_HOLD) m_cnt = m_cnt + 1;
            m_burst = burst_after;
        end
        m_owner = nxt;
    endtask

    task automatic set_in(input logic [1:0] req, input logic [1:0] last, input logic ready);
        @(negedge clk);
        i_req       = req;
        i_last      = last;
        i_out_ready = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        i_req       = 2'b00;
        i_last      = 2'b00;
        i_out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req = 2'b11;
        i_last = 2'b00;
        i_out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (o_en !== 1'b0) $display("FAIL reset_en got %0b want 0", o_en); else pass_cnt++;
        total_cnt++;
        if (o_cmd !== 1'b0) $display("FAIL reset_cmd got %0b want 0", o_cmd); else pass_cnt++;
        total_cnt++;
        if (o_grant !== 2'b00) $display("FAIL reset_grant got %b want 00", o_grant); else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_alternate();
        logic       want_cmd;
        logic [1:0] want_grant;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(2'b11, 2'b11, 1'b1);
            want_cmd   = (i == 0) ? 1'b0 : 1'((i - 1) % 2);
            want_grant = (i == 0) ? 2'b00 : (want_cmd ? 2'b10 : 2'b01);
            total_cnt++;
            if (o_en !== (i != 0)) $display("FAIL alt_en[%0d] got %0b want %0b", i, o_en, i != 0);
            else pass_cnt++;
            total_cnt++;
            if (o_cmd !== want_cmd) $display("FAIL alt_cmd[%0d] got %0b want %0b", i, o_cmd, want_cmd);
            else pass_cnt++;
            total_cnt++;
            if (o_grant !== want_grant) $display("FAIL alt_grant[%0d] got %b want %b", i, o_grant, want_grant);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_single_high();
        do_reset();
        set_in(2'b10, 2'b11, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(2'b10, 2'b11, 1'b1);
            total_cnt++;
            if ({o_en, o_cmd, o_grant} !== 4'b1110)
                $display("FAIL high_hold[%0d] got en/cmd/grant %b want 1110", i, {o_en, o_cmd, o_grant});
            else pass_cnt++;
            tick();
        end
        set_in(2'b00, 2'b11, 1'b1);
        tick();
        set_in(2'b00, 2'b11, 1'b1);
        total_cnt++;
        if (o_en !== 1'b0) $display("FAIL high_drop_en got %0b want 0", o_en); else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        set_in(2'b11, 2'b11, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(2'b11, 2'b11, 1'b0);
            total_cnt++;
            if ({o_en, o_cmd, o_grant} !== 4'b1000)
                $display("FAIL stall[%0d] got en/cmd/grant %b want 1000", i, {o_en, o_cmd, o_grant});
            else pass_cnt++;
            tick();
        end
        set_in(2'b11, 2'b11, 1'b1);
        total_cnt++;
        if ({o_cmd, o_grant} !== 3'b001) $display("FAIL stall_release got cmd/grant %b want 001", {o_cmd, o_grant});
        else pass_cnt++;
        tick();
        set_in(2'b11, 2'b11, 1'b1);
        total_cnt++;
        if ({o_cmd, o_grant} !== 3'b110) $display("FAIL stall_switch got cmd/grant %b want 110", {o_cmd, o_grant});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b10, 2'b00, 1'b1);
            tick();
        end
        set_in(2'b10, 2'b00, 1'b1);
        total_cnt++;
        if ({o_en, o_cmd} !== 2'b11) $display("FAIL arst_pre got en/cmd %b want 11", {o_en, o_cmd});
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({o_en, o_cmd, o_grant} !== 4'b0000)
            $display("FAIL arst_drop got en/cmd/grant %b want 0000", {o_en, o_cmd, o_grant});
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(2'b11, 2'b11, 1'b1);
        tick();
        set_in(2'b11, 2'b11, 1'b1);
        total_cnt++;
        if ({o_en, o_cmd, o_grant} !== 4'b1001)
            $display("FAIL arst_low_first got en/cmd/grant %b want 1001", {o_en, o_cmd, o_grant});
        else pass_cnt++;
        tick();
    endtask

`ifdef ARB_BURST_LOCK_EN
    task automatic test_burst_last();
        int  lo;
        bit  switched;
        lo = 0;
        switched = 0;
        do_reset();
        for (int i = 0; i < 20 && !switched; i++) begin
            set_in(2'b11, {1'b0, lo == 3}, 1'b1);
            if (o_cmd === 1'b1) switched = 1;
            else if (o_grant === 2'b01) lo++;
            tick();
        end
        total_cnt++;
        if (!switched || lo != 4) $display("FAIL burst_last got low_xfers %0d switched %0b want 4 1", lo, switched);
        else pass_cnt++;
    endtask

    task automatic test_forced_switch();
        int lo;
        bit switched;
        lo = 0;
        switched = 0;
        do_reset();
        for (int i = 0; i < 60 && !switched; i++) begin
            set_in(2'b11, 2'b00, 1'b1);
            if (o_cmd === 1'b1) switched = 1;
            else if (o_grant === 2'b01) lo++;
            tick();
        end
        total_cnt++;
        if (!switched || lo != MAX_HOLD)
            $display("FAIL forced_switch got low_xfers %0d switched %0b want %0d 1", lo, switched, MAX_HOLD);
        else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        logic       want_en;
        logic       want_cmd;
        logic [1:0] want_grant;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_in(2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            want_en    = (m_owner >= 0);
            want_cmd   = (m_owner == 1);
            want_grant = (m_owner == 0) ? {1'b0, i_out_ready} :
                         (m_owner == 1) ? {i_out_ready, 1'b0} : 2'b00;
            total_cnt++;
            if (o_en !== want_en) $display("FAIL rand_en[%0d] got %0b want %0b", i, o_en, want_en);
            else pass_cnt++;
            total_cnt++;
            if (o_cmd !== want_cmd) $display("FAIL rand_cmd[%0d] got %0b want %0b", i, o_cmd, want_cmd);
            else pass_cnt++;
            total_cnt++;
            if (o_grant !== want_grant) $display("FAIL rand_grant[%0d] got %b want %b", i, o_grant, want_grant);
            else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single_high();
        test_stall();
        test_async_reset();
`ifdef ARB_BURST_LOCK_EN
        test_burst_last();
        test_forced_switch();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
